// File: rtl/lif_sched_pkg.sv
// Shared types and sizing helpers for the LIF time-step scheduler.
// Holds the phase state encoding, weight width and phase-counter sizing.
package lif_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INTEGRATE = 2'd1,
    SETTLE    = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam int WEIGHT_W          = 16;
  localparam int INTEG_CYCLES_DEF  = 32;
  localparam int SETTLE_CYCLES_DEF = 3;

  // Counter only ever holds (length - 1), so clog2 of the longer phase suffices.
  function automatic int cnt_width(input int integ, input int settle);
    int m;
    m = (integ > settle) ? integ : settle;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  localparam int CNT_W = cnt_width(INTEG_CYCLES_DEF, SETTLE_CYCLES_DEF);

endpackage

// File: rtl/lif_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Zero latency; grants nothing while enable is low.
module lif_rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             enable,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx
);

  always_comb begin
    logic found;
    int   idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (enable && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/lif_step_scheduler.sv
// Time-step controller: integrate window with round-robin event arbitration, settle, report spikes.
// Event-to-neuron latency 1 cycle; requesters are held off (req_ready low) outside INTEGRATE.
module lif_step_scheduler
  import lif_sched_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int NUM_NEURONS   = 16,
  parameter int ID_W          = 6,
  parameter int INTEG_CYCLES  = 32,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         step_start,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ID_W-1:0]      req_neuron_id,
  input  logic [NUM_REQ*WEIGHT_W-1:0]  req_weight,
  output logic [WEIGHT_W-1:0]          nrn_current,
  output logic [NUM_NEURONS-1:0]       nrn_valid,
  input  logic [NUM_NEURONS-1:0]       nrn_spike,
  output logic                         busy,
  output logic                         step_done,
  output logic [NUM_NEURONS-1:0]       spike_vec,
  output logic [15:0]                  drop_count
);

  localparam int CW = cnt_width(INTEG_CYCLES, SETTLE_CYCLES);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CW-1:0]   INTEG_LOAD  = CW'(INTEG_CYCLES - 1);
  localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [ID_W:0]   NRN_LIMIT   = (ID_W + 1)'(NUM_NEURONS);
  localparam logic [PW-1:0]   LAST_REQ    = PW'(NUM_REQ - 1);

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [PW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [NUM_NEURONS-1:0]  nrn_valid_q, nrn_valid_d;
  logic [NUM_NEURONS-1:0]  spike_vec_q, spike_vec_d;
  logic [WEIGHT_W-1:0]     nrn_current_q, nrn_current_d;
  logic [15:0]             drop_q, drop_d;

  logic [NUM_REQ-1:0]      grant;
  logic [PW-1:0]           grant_idx;
  logic                    xfer;
  logic                    in_range;
  logic                    cnt_zero;
  logic [ID_W-1:0]         sel_id;
  logic [WEIGHT_W-1:0]     sel_w;

  lif_rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .enable    (state_q == INTEGRATE),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign xfer     = |(req_valid & grant);
  assign sel_id   = req_neuron_id[int'(grant_idx) * ID_W +: ID_W];
  assign sel_w    = req_weight[int'(grant_idx) * WEIGHT_W +: WEIGHT_W];
  assign in_range = ({1'b0, sel_id} < NRN_LIMIT);
  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (step_start) state_d = INTEGRATE;
      INTEGRATE: if (cnt_zero)   state_d = SETTLE;
      SETTLE:    if (cnt_zero)   state_d = DONE;
      DONE:                      state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    step_done = (state_q == DONE);
    req_ready = grant;
  end

  always_comb begin
    cnt_d         = cnt_q;
    rr_ptr_d      = rr_ptr_q;
    nrn_valid_d   = '0;
    nrn_current_d = nrn_current_q;
    spike_vec_d   = spike_vec_q;
    drop_d        = drop_q;

    case (state_q)
      IDLE: if (step_start) begin
        cnt_d       = INTEG_LOAD;
        spike_vec_d = '0;
      end
      INTEGRATE: begin
        cnt_d       = cnt_zero ? SETTLE_LOAD : cnt_q - 1'b1;
        spike_vec_d = spike_vec_q | nrn_spike;
      end
      SETTLE: begin
        if (!cnt_zero) cnt_d = cnt_q - 1'b1;
        spike_vec_d = spike_vec_q | nrn_spike;
      end
      default: ;
    endcase

    // Out-of-range ids are still consumed so a bad source cannot stall the bus.
    if (xfer) begin
      rr_ptr_d = (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
      if (in_range) begin
        nrn_valid_d   = NUM_NEURONS'(1) << sel_id;
        nrn_current_d = sel_w;
      end else if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      rr_ptr_q      <= '0;
      nrn_valid_q   <= '0;
      nrn_current_q <= '0;
      spike_vec_q   <= '0;
      drop_q        <= '0;
    end else begin
      cnt_q         <= cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      nrn_valid_q   <= nrn_valid_d;
      nrn_current_q <= nrn_current_d;
      spike_vec_q   <= spike_vec_d;
      drop_q        <= drop_d;
    end
  end

  assign nrn_valid   = nrn_valid_q;
  assign nrn_current = nrn_current_q;
  assign spike_vec   = spike_vec_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_lif_step_scheduler.sv
// Directed bench for lif_step_scheduler: timing, round-robin, drops, spike windows, abort.
module tb_lif_step_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        step_start;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [23:0] req_neuron_id;
  logic [63:0] req_weight;
  logic [15:0] nrn_current;
  logic [15:0] nrn_valid;
  logic [15:0] nrn_spike;
  logic        busy;
  logic        step_done;
  logic [15:0] spike_vec;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_pass   = 0;

  lif_step_scheduler #(
    .NUM_REQ       (4),
    .NUM_NEURONS   (16),
    .ID_W          (6),
    .INTEG_CYCLES  (32),
    .SETTLE_CYCLES (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .step_start    (step_start),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_neuron_id (req_neuron_id),
    .req_weight    (req_weight),
    .nrn_current   (nrn_current),
    .nrn_valid     (nrn_valid),
    .nrn_spike     (nrn_spike),
    .busy          (busy),
    .step_done     (step_done),
    .spike_vec     (spike_vec),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge; inputs are driven here, outputs sampled 3ns later.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [5:0] id, input logic [15:0] w);
    req_neuron_id[k*6 +: 6]   = id;
    req_weight[k*16 +: 16]    = w;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, prev_g, done_c, pulses;
    int grants [4];
    bit seen;

    rst = 1'b1; step_start = 1'b0; req_valid = '0;
    req_neuron_id = '0; req_weight = '0; nrn_spike = '0;
    next_cyc(); next_cyc();
    rst = 1'b0;
    #3;
    chk("rst_busy",   32'(busy),        32'h0);
    chk("rst_done",   32'(step_done),   32'h0);
    chk("rst_nvalid", 32'(nrn_valid),   32'h0);
    chk("rst_ncur",   32'(nrn_current), 32'h0);
    chk("rst_svec",   32'(spike_vec),   32'h0);
    chk("rst_drop",   32'(drop_count),  32'h0);

    // Idle with requests pending: nothing may be granted.
    req_valid = 4'hF;
    for (int i = 0; i < 10; i++) next_cyc();
    #3;
    chk("idle_busy",  32'(busy),      32'h0);
    chk("idle_rdy",   32'(req_ready), 32'h0);
    chk("idle_nval",  32'(nrn_valid), 32'h0);
    chk("idle_svec",  32'(spike_vec), 32'h0);

    // Step 1: single event, spike in SETTLE, DONE timing.
    next_cyc();                         // cycle 0
    req_valid = '0; step_start = 1'b1;
    #3;
    chk("s1_busy_c0", 32'(busy), 32'h0);
    next_cyc();                         // cycle 1
    step_start = 1'b0;
    set_req(0, 6'd5, 16'h0120);
    req_valid = 4'b0001;
    #3;
    chk("s1_busy_c1", 32'(busy),      32'h1);
    chk("s1_rdy_c1",  32'(req_ready), 32'h1);
    next_cyc();                         // cycle 2
    req_valid = '0;
    #3;
    chk("s1_nval_c2", 32'(nrn_valid),   32'h0020);
    chk("s1_ncur_c2", 32'(nrn_current), 32'h0120);
    chk("s1_rdy_c2",  32'(req_ready),   32'h0);
    next_cyc();                         // cycle 3
    #3;
    chk("s1_nval_c3", 32'(nrn_valid),   32'h0);
    chk("s1_ncur_c3", 32'(nrn_current), 32'h0120);
    seen = 1'b0; done_c = -1;
    for (int c = 4; c <= 60 && !seen; c++) begin
      next_cyc();
      nrn_spike = (c == 34) ? 16'h0008 : 16'h0000;
      #3;
      if (step_done) begin seen = 1'b1; done_c = c; end
    end
    chk("s1_done_cyc", 32'(done_c),    32'd36);
    chk("s1_svec",     32'(spike_vec), 32'h0008);
    next_cyc();                         // IDLE, spike must be ignored
    nrn_spike = 16'h0080;
    #3;
    chk("s1_done_once", 32'(step_done), 32'h0);
    chk("s1_idle_busy", 32'(busy),      32'h0);
    next_cyc();
    nrn_spike = '0;
    #3;
    chk("idle_spike_ign", 32'(spike_vec), 32'h0008);
    step_start = 1'b1;

    // Step 2: all requesters valid; rr_ptr is 1 after step 1's grant to requester 0.
    for (int k = 0; k < 4; k++) begin
      set_req(k, 6'(k + 1), 16'(16'h0100 + k));
      grants[k] = 0;
    end
    prev_g = 0;
    for (int c = 1; c <= 32; c++) begin
      next_cyc();
      if (c == 1) begin
        step_start = 1'b0;
        req_valid  = 4'hF;
      end
      #3;
      g = (1 + c - 1) % 4;
      if (c == 1) begin
        chk("s2_svec_clr", 32'(spike_vec), 32'h0);
        chk("s2_busy",     32'(busy),      32'h1);
      end
      chk($sformatf("rr_rdy_c%0d", c), 32'(req_ready), 32'(1 << g));
      if (c > 1) begin
        chk($sformatf("rr_nval_c%0d", c), 32'(nrn_valid),   32'(1 << (prev_g + 1)));
        chk($sformatf("rr_ncur_c%0d", c), 32'(nrn_current), 32'(16'h0100 + prev_g));
      end
      for (int k = 0; k < 4; k++) if (req_ready[k]) grants[k]++;
      prev_g = g;
    end
    for (int k = 0; k < 4; k++) chk($sformatf("rr_cnt%0d", k), 32'(grants[k]), 32'd8);
    next_cyc();                         // cycle 33, SETTLE
    #3;
    chk("settle_rdy",  32'(req_ready), 32'h0);
    chk("last_grant",  32'(nrn_valid), 32'(1 << (prev_g + 1)));
    req_valid = '0;
    next_cyc();                         // cycle 34: start during SETTLE
    step_start = 1'b1;
    next_cyc();
    step_start = 1'b0;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      #3;
      if (step_done) pulses++;
      next_cyc();
    end
    #3;
    chk("ign_start_done", 32'(pulses), 32'd1);
    chk("ign_start_busy", 32'(busy),   32'h0);

    // Step 3: out-of-range ids, saturation, boundary id, then abort.
    next_cyc();
    step_start = 1'b1;
    next_cyc();                         // c1, rr_ptr = 1
    step_start = 1'b0;
    set_req(2, 6'd20, 16'h0777);
    req_valid = 4'b0100;
    #3;
    chk("drop_rdy", 32'(req_ready), 32'h4);
    next_cyc();                         // c2, rr_ptr = 3
    req_valid = '0;
    #3;
    chk("drop_nval", 32'(nrn_valid),  32'h0);
    chk("drop_cnt1", 32'(drop_count), 32'h1);
    next_cyc();                         // c3
    force dut.drop_q = 16'hFFFF;
    #1;
    release dut.drop_q;
    req_valid = 4'b0100;
    #2;
    chk("sat_rdy", 32'(req_ready), 32'h4);
    next_cyc();                         // c4, rr_ptr = 3
    set_req(1, 6'd15, 16'h0ABC);
    req_valid = 4'b0010;
    #3;
    chk("sat_cnt",  32'(drop_count), 32'hFFFF);
    chk("sat_nval", 32'(nrn_valid),  32'h0);
    chk("id15_rdy", 32'(req_ready),  32'h2);
    next_cyc();                         // c5, rr_ptr = 2
    set_req(0, 6'd16, 16'h0555);
    req_valid = 4'b0001;
    #3;
    chk("id15_nval", 32'(nrn_valid),   32'h8000);
    chk("id15_ncur", 32'(nrn_current), 32'h0ABC);
    chk("id16_rdy",  32'(req_ready),   32'h1);
    next_cyc();                         // c6, rr_ptr = 1; abort with pending transfer
    set_req(3, 6'd2, 16'h0333);
    req_valid = 4'b1000;
    rst = 1'b1;
    #3;
    chk("id16_nval",  32'(nrn_valid),  32'h0);
    chk("id16_drop",  32'(drop_count), 32'hFFFF);
    chk("abort_rdy",  32'(req_ready),  32'h8);
    next_cyc();
    rst = 1'b0;
    req_valid = '0;
    #3;
    chk("abort_busy", 32'(busy),       32'h0);
    chk("abort_nval", 32'(nrn_valid),  32'h0);
    chk("abort_drop", 32'(drop_count), 32'h0);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (step_done) pulses++;
      next_cyc();
      #3;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);

    // Pointer must be back at 0 after reset.
    step_start = 1'b1;
    next_cyc();
    step_start = 1'b0;
    req_valid = 4'hF;
    #3;
    chk("ptr_reset_rdy", 32'(req_ready), 32'h1);
    next_cyc();
    req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
